// File: rtl/windowed_energy.sv
// Streaming windowed |x|^2 sum: squares each I/Q sample, keeps a running
// sum over the last L samples, scales by a right shift and saturates.
//
// Ports:
//   clk, reset (sync, active-high), clear (sync flush)
//   len    window length, latched on the first sample after IDLE
//   shift  output right shift, applied at every output-stage load
//   i_*    AXIS input {I, Q}, o_* AXIS output (o_tuser = window full)
module windowed_energy #(
    parameter int IN_WIDTH        = 16,
    parameter int OUT_WIDTH       = 16,
    parameter int MAX_LEN         = 512,
    parameter bit RESTART_ON_LAST = 1'b0,
    localparam int MAG_W = 2 * IN_WIDTH,
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int ACC_W = MAG_W + LEN_W,
    localparam int SH_W  = $clog2(ACC_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [LEN_W-1:0]     len,
    input  logic [SH_W-1:0]      shift,
    input  logic [MAG_W-1:0]     i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [OUT_WIDTH-1:0] o_tdata,
    output logic                 o_tuser,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready
);

    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t state, state_n;

    logic flush;
    logic adv;
    logic accept;
    logic step;

    assign flush    = reset || clear;
    assign adv      = !o_tvalid || o_tready;
    assign i_tready = adv && !flush;
    assign accept   = i_tvalid && i_tready;

    // Stage 1: component squares
    logic signed [IN_WIDTH-1:0] in_i;
    logic signed [IN_WIDTH-1:0] in_q;
    logic signed [MAG_W-1:0]    prod_i;
    logic signed [MAG_W-1:0]    prod_q;
    logic [MAG_W-1:0]           s1_pi;
    logic [MAG_W-1:0]           s1_pq;
    logic                       s1_valid;
    logic                       s1_last;

    assign in_i   = i_tdata[MAG_W-1:IN_WIDTH];
    assign in_q   = i_tdata[IN_WIDTH-1:0];
    assign prod_i = MAG_W'(in_i) * MAG_W'(in_i);
    assign prod_q = MAG_W'(in_q) * MAG_W'(in_q);

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            s1_last  <= accept && i_tlast;
            s1_pi    <= $unsigned(prod_i);
            s1_pq    <= $unsigned(prod_q);
        end
    end

    // Stage 2: magnitude; max 2^(MAG_W-1) fits in MAG_W bits
    logic [MAG_W-1:0] s2_mag;
    logic             s2_valid;
    logic             s2_last;

    always_ff @(posedge clk) begin
        if (flush) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_mag   <= s1_pi + s1_pq;
        end
    end

    // Stage 3: window FSM, accumulator, scale and saturate
    logic [MAG_W-1:0]     mem [MAX_LEN];
    logic [PTR_W-1:0]     ptr, ptr_n;
    logic [LEN_W-1:0]     cnt, cnt_n;
    logic [LEN_W-1:0]     len_q, len_q_n;
    logic [LEN_W-1:0]     len_eff;
    logic [LEN_W-1:0]     win;
    logic [ACC_W-1:0]     acc, acc_n;
    logic [ACC_W-1:0]     acc_sum;
    logic [ACC_W-1:0]     acc_sh;
    logic [MAG_W-1:0]     old;
    logic [OUT_WIDTH-1:0] sat;
    logic                 full_now;

    assign step    = adv && s2_valid;
    assign len_eff = (len == '0) ? ONE_L :
                     (len > MAX_L) ? MAX_L : len;
    // The length in force: the live input while IDLE, the latched one after
    assign win     = (state == IDLE) ? len_eff : len_q;
    // Oldest entry sits at the write pointer; read before the write lands
    assign old     = mem[ptr];
    assign full_now = (state == FULL) || (cnt + ONE_L == win);

    assign acc_sum = ((state == IDLE) ? '0 : acc)
                   + ACC_W'(s2_mag)
                   - ((state == FULL) ? ACC_W'(old) : '0);
    assign acc_sh  = acc_sum >> shift;
    assign sat     = (|acc_sh[ACC_W-1:OUT_WIDTH]) ? '1
                                                  : acc_sh[OUT_WIDTH-1:0];

    always_comb begin
        state_n = state;
        acc_n   = acc;
        ptr_n   = ptr;
        cnt_n   = cnt;
        len_q_n = len_q;
        if (step) begin
            acc_n = acc_sum;
            if (LEN_W'(ptr) == win - ONE_L) begin
                ptr_n = '0;
            end else begin
                ptr_n = ptr + PTR_W'(1);
            end
            if (state == IDLE) begin
                len_q_n = len_eff;
            end
            if (state != FULL) begin
                cnt_n = cnt + ONE_L;
            end
            state_n = full_now ? FULL : FILL;
            // Packet boundary: this sample is summed, then the window empties
            if (RESTART_ON_LAST && s2_last) begin
                state_n = IDLE;
                acc_n   = '0;
                ptr_n   = '0;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state    <= IDLE;
            acc      <= '0;
            ptr      <= '0;
            cnt      <= '0;
            len_q    <= ONE_L;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tuser  <= 1'b0;
            o_tlast  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            len_q <= len_q_n;
            if (adv) begin
                o_tvalid <= s2_valid;
                if (s2_valid) begin
                    o_tdata <= sat;
                    o_tuser <= full_now;
                    o_tlast <= s2_last;
                end
            end
        end
    end

    // Stale contents are harmless: FILL never subtracts them
    always_ff @(posedge clk) begin
        if (step && !flush) begin
            mem[ptr] <= s2_mag;
        end
    end

endmodule
